// File: rtl/disp_share_arb_amisha_pkg.sv
// Shared definitions for the display-share arbiter: FSM state encodings,
// default idle display values and a small helper for the "other owner" lookup.
package disp_share_arb_amisha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic [15:0] IDLE_HEX_DEF = 16'h0000;
  localparam logic [3:0]  IDLE_DP_DEF  = 4'b1111;   // dp is active-low: all off

  // Grant state of the client that does not currently own the display.
  function automatic arb_state_e other_gnt(input arb_state_e s);
    return (s == ST_GNT0) ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/disp_share_arb_amisha_if.sv
// Bundle of client request/data lines and display-mux outputs for the
// display-share arbiter.
//   master : client side (drives req/data/dp, observes grants and display)
//   slave  : arbiter side
interface disp_share_arb_amisha_if;
  logic        req0_amisha;
  logic [15:0] data0_amisha;
  logic [3:0]  dp0_amisha;
  logic        req1_amisha;
  logic [15:0] data1_amisha;
  logic [3:0]  dp1_amisha;
  logic        gnt0_amisha;
  logic        gnt1_amisha;
  logic [3:0]  hex3_amisha;
  logic [3:0]  hex2_amisha;
  logic [3:0]  hex1_amisha;
  logic [3:0]  hex0_amisha;
  logic [3:0]  dp_out_amisha;
  logic        switch_amisha;

  modport master (
    output req0_amisha, data0_amisha, dp0_amisha,
    output req1_amisha, data1_amisha, dp1_amisha,
    input  gnt0_amisha, gnt1_amisha,
    input  hex3_amisha, hex2_amisha, hex1_amisha, hex0_amisha,
    input  dp_out_amisha, switch_amisha
  );

  modport slave (
    input  req0_amisha, data0_amisha, dp0_amisha,
    input  req1_amisha, data1_amisha, dp1_amisha,
    output gnt0_amisha, gnt1_amisha,
    output hex3_amisha, hex2_amisha, hex1_amisha, hex0_amisha,
    output dp_out_amisha, switch_amisha
  );
endinterface

// File: rtl/disp_share_arb_amisha_hold_timer.sv
// Dwell timer for the display arbiter: saturating up-counter with
// synchronous clear, count enable and a flag at HOLD_CYCLES-1.
// Ports:
//   clk_amisha, reset_amisha : clock, async active-high reset
//   clr_amisha               : restart the dwell (priority over enable)
//   en_amisha                : count this cycle
//   at_max_amisha            : counter has reached HOLD_CYCLES-1
module disp_hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk_amisha,
  input  logic reset_amisha,
  input  logic clr_amisha,
  input  logic en_amisha,
  output logic at_max_amisha
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] hold_cnt;

  assign at_max_amisha = (hold_cnt == CNT_MAX);

  // Saturates instead of wrapping so an uncontested owner sits at the
  // terminal value and a late contender is served on the next edge.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha)
      hold_cnt <= '0;
    else if (clr_amisha)
      hold_cnt <= '0;
    else if (en_amisha && !at_max_amisha)
      hold_cnt <= hold_cnt + 1'b1;
  end

endmodule

// File: rtl/disp_share_arb_amisha.sv
// Display-share arbiter: two clients compete for the 4-digit hex display.
// Round-robin tie-break, minimum dwell before a contested grant moves,
// immediate release when the owner drops its request.
// Ports:
//   clk_amisha, reset_amisha : clock, async active-high reset
//   bus (slave)              : client req/data/dp in; gnt, hex3..0, dp_out,
//                              switch pulse out (all registered)
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | nobody owns the display, idle pattern shown
//   GNT0    | client 0 owns the display
//   GNT1    | client 1 owns the display
module disp_share_arb_amisha
  import disp_share_arb_amisha_pkg::*;
#(
  parameter int          HOLD_CYCLES = 50_000_000,
  parameter logic [15:0] IDLE_HEX    = IDLE_HEX_DEF,
  parameter logic [3:0]  IDLE_DP     = IDLE_DP_DEF
) (
  input  logic                 clk_amisha,
  input  logic                 reset_amisha,
  disp_share_arb_amisha_if.slave bus
);

  arb_state_e  state_q, state_d;
  logic        rr_last_q;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  dp_q, dp_d;
  logic        switch_q;
  logic        hold_at_max;
  logic        entering_gnt;

  assign entering_gnt = (state_d != state_q) && (state_d != ST_IDLE);

  disp_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk_amisha    (clk_amisha),
    .reset_amisha  (reset_amisha),
    .clr_amisha    (entering_gnt),
    .en_amisha     (state_q != ST_IDLE),
    .at_max_amisha (hold_at_max)
  );

  always_comb begin
    state_d = state_q;
    disp_d  = IDLE_HEX;
    dp_d    = IDLE_DP;

    case (state_q)
      ST_IDLE: begin
        // rr_last==1 means client 1 was served last, so client 0 wins a tie.
        if (bus.req0_amisha && bus.req1_amisha)
          state_d = rr_last_q ? ST_GNT0 : ST_GNT1;
        else if (bus.req0_amisha)
          state_d = ST_GNT0;
        else if (bus.req1_amisha)
          state_d = ST_GNT1;
      end
      ST_GNT0: begin
        if (!bus.req0_amisha)
          state_d = bus.req1_amisha ? ST_GNT1 : ST_IDLE;
        else if (bus.req1_amisha && hold_at_max)
          state_d = other_gnt(state_q);
      end
      ST_GNT1: begin
        if (!bus.req1_amisha)
          state_d = bus.req0_amisha ? ST_GNT0 : ST_IDLE;
        else if (bus.req0_amisha && hold_at_max)
          state_d = other_gnt(state_q);
      end
      default: state_d = ST_IDLE;
    endcase

    // Display follows the next owner so grant and digits change together.
    case (state_d)
      ST_GNT0: begin
        disp_d = bus.data0_amisha;
        dp_d   = bus.dp0_amisha;
      end
      ST_GNT1: begin
        disp_d = bus.data1_amisha;
        dp_d   = bus.dp1_amisha;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      disp_q    <= IDLE_HEX;
      dp_q      <= IDLE_DP;
      switch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      disp_q   <= disp_d;
      dp_q     <= dp_d;
      switch_q <= (state_d != state_q);
      if (entering_gnt)
        rr_last_q <= (state_d == ST_GNT1);
    end
  end

  assign bus.gnt0_amisha   = (state_q == ST_GNT0);
  assign bus.gnt1_amisha   = (state_q == ST_GNT1);
  assign bus.hex3_amisha   = disp_q[15:12];
  assign bus.hex2_amisha   = disp_q[11:8];
  assign bus.hex1_amisha   = disp_q[7:4];
  assign bus.hex0_amisha   = disp_q[3:0];
  assign bus.dp_out_amisha = dp_q;
  assign bus.switch_amisha = switch_q;

endmodule

// File: tb/tb_disp_share_arb_amisha.sv
module tb_disp_share_arb_amisha;

  localparam int HOLD = 4;

  logic clk_amisha;
  logic reset_amisha;
  int   n_tests;
  int   n_fail;

  disp_share_arb_amisha_if bus ();

  disp_share_arb_amisha #(.HOLD_CYCLES(HOLD)) dut (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .bus          (bus.slave)
  );

  initial begin
    clk_amisha = 1'b0;
    forever #5 clk_amisha = ~clk_amisha;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] gnt, input logic [15:0] hex,
                            input logic [3:0] dp, input logic sw);
    check({tag, ".gnt"}, {30'd0, bus.gnt1_amisha, bus.gnt0_amisha}, {30'd0, gnt});
    check({tag, ".hex"}, {16'd0, bus.hex3_amisha, bus.hex2_amisha, bus.hex1_amisha, bus.hex0_amisha},
          {16'd0, hex});
    check({tag, ".dp"}, {28'd0, bus.dp_out_amisha}, {28'd0, dp});
    check({tag, ".sw"}, {31'd0, bus.switch_amisha}, {31'd0, sw});
  endtask

  task automatic step();
    @(posedge clk_amisha);
    #1;
  endtask

  // Reference model state for the random phase.
  int          m_st;      // 0 idle, 1 client0, 2 client1
  int          m_cnt;
  int          m_rr;      // last served client index
  logic [15:0] m_disp;
  logic [3:0]  m_dp;
  logic        m_sw;

  initial begin
    logic r0, r1, mine, oth;
    int nxt, run, prev_own, cur;

    n_tests = 0;
    n_fail  = 0;
    reset_amisha = 1'b1;
    bus.req0_amisha = 0; bus.data0_amisha = 16'h0; bus.dp0_amisha = 4'h0;
    bus.req1_amisha = 0; bus.data1_amisha = 16'h0; bus.dp1_amisha = 4'h0;

    #3;
    expect_out("reset", 2'b00, 16'h0000, 4'b1111, 1'b0);
    #9 reset_amisha = 1'b0;
    step();
    expect_out("idle_after_reset", 2'b00, 16'h0000, 4'b1111, 1'b0);

    // Both request in IDLE: client 0 wins first tie, dwell exactly HOLD cycles.
    bus.req0_amisha = 1; bus.data0_amisha = 16'h1234; bus.dp0_amisha = 4'b1110;
    bus.req1_amisha = 1; bus.data1_amisha = 16'hABCD; bus.dp1_amisha = 4'b0111;
    step();
    expect_out("tie_gnt0", 2'b01, 16'h1234, 4'b1110, 1'b1);
    for (int i = 1; i < HOLD; i++) begin
      step();
      expect_out("dwell0", 2'b01, 16'h1234, 4'b1110, 1'b0);
    end
    step();
    expect_out("rotate_gnt1", 2'b10, 16'hABCD, 4'b0111, 1'b1);
    for (int i = 1; i < HOLD; i++) begin
      step();
      expect_out("dwell1", 2'b10, 16'hABCD, 4'b0111, 1'b0);
    end
    step();
    expect_out("rotate_back_gnt0", 2'b01, 16'h1234, 4'b1110, 1'b1);

    // Uncontested owner, live data with one-cycle latency.
    bus.req1_amisha = 0;
    step();
    expect_out("uncontested", 2'b01, 16'h1234, 4'b1110, 1'b0);
    bus.data0_amisha = 16'h5678;
    step();
    expect_out("data_follow", 2'b01, 16'h5678, 4'b1110, 1'b0);

    // Release with nobody else waiting, long idle, re-request.
    bus.req0_amisha = 0;
    step();
    expect_out("release_idle", 2'b00, 16'h0000, 4'b1111, 1'b1);
    step();
    expect_out("idle_hold", 2'b00, 16'h0000, 4'b1111, 1'b0);
    repeat (100) step();
    expect_out("idle_100", 2'b00, 16'h0000, 4'b1111, 1'b0);
    bus.req1_amisha = 1;
    step();
    expect_out("rereq_gnt1", 2'b10, 16'hABCD, 4'b0111, 1'b1);

    // Owner 1 drops request early in dwell while client 0 waits.
    bus.req0_amisha = 1; bus.data0_amisha = 16'h1111; bus.dp0_amisha = 4'b0000;
    step();
    expect_out("contested_wait", 2'b10, 16'hABCD, 4'b0111, 1'b0);
    bus.req1_amisha = 0;
    step();
    expect_out("early_release", 2'b01, 16'h1111, 4'b0000, 1'b1);

    // Asynchronous reset mid-grant, checked without a clock edge.
    reset_amisha = 1'b1;
    #1;
    expect_out("reset_mid_grant", 2'b00, 16'h0000, 4'b1111, 1'b0);
    bus.req0_amisha = 0; bus.req1_amisha = 0;
    #2 reset_amisha = 1'b0;

    // Random phase against a cycle model.
    m_st = 0; m_cnt = 0; m_rr = 1; m_disp = 16'h0; m_dp = 4'hF; m_sw = 0;
    r0 = 0; r1 = 0; run = 0; prev_own = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) r0 = ~r0;
      if ($urandom_range(0, 7) == 0) r1 = ~r1;
      bus.req0_amisha  = r0;
      bus.req1_amisha  = r1;
      bus.data0_amisha = 16'($urandom);
      bus.dp0_amisha   = 4'($urandom);
      bus.data1_amisha = 16'($urandom);
      bus.dp1_amisha   = 4'($urandom);

      if (m_st == 0) begin
        if (r0 && r1) nxt = (m_rr == 1) ? 1 : 2;
        else if (r0)  nxt = 1;
        else if (r1)  nxt = 2;
        else          nxt = 0;
      end else begin
        mine = (m_st == 1) ? r0 : r1;
        oth  = (m_st == 1) ? r1 : r0;
        if (!mine)                        nxt = oth ? 3 - m_st : 0;
        else if (oth && m_cnt >= HOLD-1)  nxt = 3 - m_st;
        else                              nxt = m_st;
      end
      m_sw = (nxt != m_st);
      if (nxt != 0 && nxt != m_st) begin
        m_cnt = 0;
        m_rr  = nxt - 1;
      end else if (m_st != 0 && m_cnt < HOLD-1) begin
        m_cnt++;
      end
      m_disp = (nxt == 1) ? bus.data0_amisha : (nxt == 2) ? bus.data1_amisha : 16'h0000;
      m_dp   = (nxt == 1) ? bus.dp0_amisha   : (nxt == 2) ? bus.dp1_amisha   : 4'hF;
      m_st   = nxt;

      step();
      check("onehot", {31'd0, bus.gnt0_amisha & bus.gnt1_amisha}, 32'd0);
      expect_out("rand", (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00, m_disp, m_dp, m_sw);

      cur = bus.gnt0_amisha ? 1 : (bus.gnt1_amisha ? 2 : 0);
      if (cur == prev_own) begin
        run++;
      end else begin
        if (prev_own != 0 && cur != 0 && ((prev_own == 1) ? r0 : r1))
          check("min_dwell", {31'd0, run >= HOLD}, 32'd1);
        run = 1;
      end
      prev_own = cur;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
